periph_bus_arb: RTL and testbench
=================================

Name: periph_bus_arb

Overview:
- Round-robin arbiter and transfer sequencer that shares one peripheral register bus (ce/we/addr/din/dout) among NREQ masters, e.g. CPU and a debug/DMA master.
- Sits between the masters and the GPIO peripheral.
- Runs one single-beat transfer at a time, drives ce for exactly one cycle, captures read data, and returns a one-cycle ack to the winning master.

Parameters:
- NREQ, 2: number of requesting masters; legal range 2..4.
- AW, 3: peripheral address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- m_req  in  NREQ  per-master transfer request; level, held until ack.
- m_we  in  NREQ  per-master write enable: 1 = write, 0 = read.
- m_addr  in  NREQ*AW  per-master address; master i uses bits [i*AW +: AW].
- m_wdata  in  NREQ*DW  per-master write data; master i uses bits [i*DW +: DW].
- m_lock  in  NREQ  per-master bus-lock request; only used with ARB_LOCK_EN.
- m_ack  out  NREQ  one-hot, one-cycle completion pulse.
- m_rdata  out  DW  read data, shared by all masters; valid in the ack cycle of a read.
- bus_ce  out  1  peripheral chip enable.
- bus_we  out  1  peripheral write enable.
- bus_addr  out  AW  peripheral address.
- bus_din  out  DW  peripheral write data.
- bus_dout  in  DW  peripheral read data; combinational from the peripheral, sampled at the end of the ACCESS cycle.

Behaviour:
- All outputs are registered.
- Reset (sync, rst=1 at a posedge) gives:
  - state=IDLE;
  - bus_ce=0, bus_we=0, bus_addr=0, bus_din=0;
  - m_ack=0, m_rdata=0;
  - rr_last=NREQ-1, so master 0 has priority first;
  - gnt=0, lock_own=0.
- FSM has 3 states: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - If m_req==0, stay in IDLE.
  - Otherwise pick the winner w as the first set bit of m_req, searching from rr_last+1 upward and wrapping modulo NREQ.
  - Register gnt=w, bus_ce=1, bus_we=m_we[w], bus_addr=m_addr[w], bus_din=m_wdata[w]; go to ACCESS.
- ACCESS:
  - bus_ce is high for exactly this one cycle.
  - At the closing edge:
    - if bus_we=0, m_rdata<=bus_dout; on writes m_rdata holds its old value;
    - bus_ce<=0, bus_we<=0, m_ack[gnt]<=1, rr_last<=gnt;
    - go to ACK.
- ACK:
  - m_ack is high for this one cycle only, then cleared.
  - Go to IDLE.
- Master rule: m_req must drop by the cycle after ack (the IDLE cycle). A req still high in IDLE is a new transfer.
- Master inputs are sampled only in IDLE; changes during ACCESS/ACK are ignored.
- Latency and throughput:
  - req high in IDLE cycle t -> bus_ce in cycle t+1 -> m_ack in cycle t+2.
  - Maximum rate is one transfer per 3 cycles.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,..,NREQ-1,0. No master waits more than NREQ-1 transfers.
- Simultaneous requests: resolved only by the round-robin order, never by index.
- No-request cycles: bus_ce stays 0, and bus_addr/bus_din hold their last values (don't-care while ce=0).
- Reset mid-transfer:
  - rst in ACCESS or ACK aborts the transfer.
  - No ack is issued and m_rdata is cleared.
  - A write whose ACCESS edge coincides with rst still reaches the peripheral if the peripheral samples ce on that edge. This is acceptable.
- A master must not change m_we/m_addr/m_wdata while its req is pending and unacknowledged.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - If m_lock[gnt]=1 at the ACCESS edge, set lock_own=1 and do not advance rr_last.
  - While lock_own=1, IDLE considers only m_req[gnt]. Other masters wait indefinitely.
  - lock_own clears at the ACCESS edge of a transfer with m_lock[gnt]=0, or on reset.
- Undefined:
  - m_lock is ignored (port kept, unconnected internally).
  - Arbitration is pure round-robin.

Test Plan:
- Single write then read, NREQ=2, GPIO peripheral attached:
  - master0 writes addr=0, wdata=1 -> bus_ce high exactly 1 cycle with bus_we=1, bus_din=1; m_ack=2'b01 two cycles after req.
  - master0 then reads addr=0 -> m_rdata=32'h0 in its ack cycle (the GPIO read returns the inverted bit).
- Contention: m_req=2'b11 held continuously from reset -> grant order 0,1,0,1. m_ack alternates 01,10 every 3 cycles; bus_ce duty 1 of 3.
- Write preserves rdata: read returns 32'h1 (gpio=0), then master1 writes -> m_rdata stays 32'h1 through the write's ack.
- Reset mid-op: assert rst during the ACCESS cycle -> next cycle bus_ce=0, m_ack=0, m_rdata=0. The following request from master1 with m_req=2'b11 goes to master 0 (rr_last=1).
- Stale req: master keeps req high one cycle after ack -> a second transfer starts (bus_ce again 1 cycle later). Dropping req in that IDLE cycle starts no transfer.
- ARB_LOCK_EN: master0 holds m_lock=1 over 3 transfers with m_req=2'b11 -> master1 gets no ack until master0's transfer with m_lock=0 completes, then master1 is granted next. With the macro undefined, the same stimulus alternates grants.

Source files
------------

// File: rtl/periph_bus_arb.sv
// Round-robin arbiter and single-beat transfer sequencer sharing one peripheral register bus.
// Define ARB_LOCK_EN to let the granted master hold the bus across transfers via i_m_lock.
module periph_bus_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_m_req,
  input  logic [NREQ-1:0]      i_m_we,
  input  logic [NREQ*AW-1:0]   i_m_addr,
  input  logic [NREQ*DW-1:0]   i_m_wdata,
  input  logic [NREQ-1:0]      i_m_lock,
  output logic [NREQ-1:0]      o_m_ack,
  output logic [DW-1:0]        o_m_rdata,
  output logic                 o_bus_ce,
  output logic                 o_bus_we,
  output logic [AW-1:0]        o_bus_addr,
  output logic [DW-1:0]        o_bus_din,
  input  logic [DW-1:0]        i_bus_dout
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e          r_state, w_state_d;
  logic [IW-1:0]   r_gnt, w_gnt_d;
  logic [IW-1:0]   r_rr_last, w_rr_last_d;
  logic            r_bus_ce, w_bus_ce_d;
  logic            r_bus_we, w_bus_we_d;
  logic [AW-1:0]   r_bus_addr, w_bus_addr_d;
  logic [DW-1:0]   r_bus_din, w_bus_din_d;
  logic [NREQ-1:0] r_m_ack, w_m_ack_d;
  logic [DW-1:0]   r_m_rdata, w_m_rdata_d;

  logic [NREQ-1:0] w_req_eff;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;

`ifdef ARB_LOCK_EN
  logic r_lock_own, w_lock_own_d;

  // While the bus is locked only the owning master may start a transfer.
  always_comb begin
    w_req_eff = i_m_req;
    if (r_lock_own) begin
      w_req_eff        = '0;
      w_req_eff[r_gnt] = i_m_req[r_gnt];
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_m_lock;
  assign w_req_eff     = i_m_req;
`endif

  // Descending scan so the last hit is the first requester after r_rr_last.
  always_comb begin
    w_win = r_rr_last;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_rr_last) + k) % int'(NREQ));
      if (w_req_eff[w_idx]) w_win = w_idx;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_gnt_d      = r_gnt;
    w_rr_last_d  = r_rr_last;
    w_bus_ce_d   = r_bus_ce;
    w_bus_we_d   = r_bus_we;
    w_bus_addr_d = r_bus_addr;
    w_bus_din_d  = r_bus_din;
    w_m_ack_d    = '0;
    w_m_rdata_d  = r_m_rdata;
`ifdef ARB_LOCK_EN
    w_lock_own_d = r_lock_own;
`endif
    unique case (r_state)
      StIdle: begin
        if (|w_req_eff) begin
          w_gnt_d      = w_win;
          w_bus_ce_d   = 1'b1;
          w_bus_we_d   = i_m_we[w_win];
          w_bus_addr_d = i_m_addr[int'(w_win)*int'(AW) +: AW];
          w_bus_din_d  = i_m_wdata[int'(w_win)*int'(DW) +: DW];
          w_state_d    = StAccess;
        end
      end
      StAccess: begin
        if (!r_bus_we) w_m_rdata_d = i_bus_dout;
        w_bus_ce_d       = 1'b0;
        w_bus_we_d       = 1'b0;
        w_m_ack_d[r_gnt] = 1'b1;
`ifdef ARB_LOCK_EN
        // A locking owner keeps r_rr_last so the rotation resumes where it left off.
        w_lock_own_d = i_m_lock[r_gnt];
        if (!i_m_lock[r_gnt]) w_rr_last_d = r_gnt;
`else
        w_rr_last_d = r_gnt;
`endif
        w_state_d = StAck;
      end
      StAck: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_rr_last  <= IW'(NREQ - 1);
      r_bus_ce   <= 1'b0;
      r_bus_we   <= 1'b0;
      r_bus_addr <= '0;
      r_bus_din  <= '0;
      r_m_ack    <= '0;
      r_m_rdata  <= '0;
`ifdef ARB_LOCK_EN
      r_lock_own <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_rr_last  <= w_rr_last_d;
      r_bus_ce   <= w_bus_ce_d;
      r_bus_we   <= w_bus_we_d;
      r_bus_addr <= w_bus_addr_d;
      r_bus_din  <= w_bus_din_d;
      r_m_ack    <= w_m_ack_d;
      r_m_rdata  <= w_m_rdata_d;
`ifdef ARB_LOCK_EN
      r_lock_own <= w_lock_own_d;
`endif
    end
  end

  assign o_m_ack    = r_m_ack;
  assign o_m_rdata  = r_m_rdata;
  assign o_bus_ce   = r_bus_ce;
  assign o_bus_we   = r_bus_we;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_din  = r_bus_din;

endmodule

// File: tb/tb_periph_bus_arb.sv
// Directed bench for periph_bus_arb (NREQ=2) with a one-bit GPIO model on the peripheral bus.
module tb_periph_bus_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [5:0]  m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0]  m_lock = '0;
  logic [1:0]  m_ack;
  logic [31:0] m_rdata;
  logic        bus_ce;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_din;
  logic [31:0] bus_dout;
  logic        gpio;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  periph_bus_arb #(.NREQ(2), .AW(3), .DW(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_m_req    (m_req),
    .i_m_we     (m_we),
    .i_m_addr   (m_addr),
    .i_m_wdata  (m_wdata),
    .i_m_lock   (m_lock),
    .o_m_ack    (m_ack),
    .o_m_rdata  (m_rdata),
    .o_bus_ce   (bus_ce),
    .o_bus_we   (bus_we),
    .o_bus_addr (bus_addr),
    .o_bus_din  (bus_din),
    .i_bus_dout (bus_dout)
  );

  // GPIO: address 0 holds one output bit; reads return its inverse.
  always @(posedge clk) begin
    if (rst) gpio <= 1'b0;
    else if (bus_ce && bus_we && bus_addr == 3'd0) gpio <= bus_din[0];
  end
  assign bus_dout = (bus_addr == 3'd0) ? {31'd0, ~gpio} : (32'hA5A5_0000 | {29'd0, bus_addr});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic we, input logic [2:0] a, input logic [31:0] d);
    m_we[m]          = we;
    m_addr[m*3 +: 3] = a;
    m_wdata[m*32 +: 32] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m_req = '0;
    tick();
    tick();
    n_checks++; if (bus_ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", bus_ce); end
    n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus_we); end
    n_checks++; if (bus_addr !== 3'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus_addr); end
    n_checks++; if (bus_din !== 32'd0) begin n_fail++; $display("FAIL rst_din: got %h want 0", bus_din); end
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b want 00", m_ack); end
    n_checks++; if (m_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", m_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read;
    set_m(0, 1'b1, 3'd0, 32'd1);
    m_req = 2'b01;
    tick();
    n_checks++; if (bus_ce !== 1'b1) begin n_fail++; $display("FAIL wr_ce: got %b want 1", bus_ce); end
    n_checks++; if (bus_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", bus_we); end
    n_checks++; if (bus_din !== 32'd1) begin n_fail++; $display("FAIL wr_din: got %h want 1", bus_din); end
    n_checks++; if (bus_addr !== 3'd0) begin n_fail++; $display("FAIL wr_addr: got %h want 0", bus_addr); end
    tick();
    n_checks++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got %b want 01", m_ack); end
    n_checks++; if (bus_ce !== 1'b0) begin n_fail++; $display("FAIL wr_ce_off: got %b want 0", bus_ce); end
    m_req = 2'b00;
    tick();
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL wr_ack_off: got %b want 00", m_ack); end
    set_m(0, 1'b0, 3'd0, 32'd0);
    m_req = 2'b01;
    tick();
    n_checks++; if (bus_ce !== 1'b1 || bus_we !== 1'b0) begin
      n_fail++; $display("FAIL rd_ce_we: got ce=%b we=%b want ce=1 we=0", bus_ce, bus_we);
    end
    tick();
    n_checks++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %b want 01", m_ack); end
    n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_data: got %h want 0", m_rdata); end
    m_req = 2'b00;
    tick();
  endtask

  task automatic test_write_preserves_rdata;
    set_m(0, 1'b1, 3'd0, 32'd0);
    m_req = 2'b01;
    tick(); tick();
    m_req = 2'b00;
    tick();
    set_m(0, 1'b0, 3'd0, 32'd0);
    m_req = 2'b01;
    tick(); tick();
    n_checks++; if (m_rdata !== 32'h1) begin n_fail++; $display("FAIL pr_rd: got %h want 1", m_rdata); end
    m_req = 2'b00;
    tick();
    set_m(1, 1'b1, 3'd1, 32'd5);
    m_req = 2'b10;
    tick();
    n_checks++; if (bus_ce !== 1'b1 || bus_addr !== 3'd1 || bus_din !== 32'd5) begin
      n_fail++; $display("FAIL pr_wr_bus: got ce=%b addr=%h din=%h want 1/1/5", bus_ce, bus_addr, bus_din);
    end
    tick();
    n_checks++; if (m_ack !== 2'b10) begin n_fail++; $display("FAIL pr_ack: got %b want 10", m_ack); end
    n_checks++; if (m_rdata !== 32'h1) begin n_fail++; $display("FAIL pr_hold: got %h want 1", m_rdata); end
    m_req = 2'b00;
    tick();
    n_checks++; if (m_rdata !== 32'h1) begin n_fail++; $display("FAIL pr_hold2: got %h want 1", m_rdata); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_ack;
    logic       exp_ce;
    logic [2:0] exp_addr;
    rst = 1'b1;
    m_req = 2'b00;
    tick();
    rst = 1'b0;
    set_m(0, 1'b0, 3'd2, 32'd0);
    set_m(1, 1'b0, 3'd3, 32'd0);
    m_req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_ce   = (c % 3 == 1);
      exp_ack  = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_addr = (((c / 3) % 2) == 0) ? 3'd2 : 3'd3;
      n_checks++; if (m_ack !== exp_ack) begin
        n_fail++; $display("FAIL cont_ack c=%0d: got %b want %b", c, m_ack, exp_ack);
      end
      n_checks++; if (bus_ce !== exp_ce) begin
        n_fail++; $display("FAIL cont_ce c=%0d: got %b want %b", c, bus_ce, exp_ce);
      end
      if (exp_ce) begin
        n_checks++; if (bus_addr !== exp_addr) begin
          n_fail++; $display("FAIL cont_addr c=%0d: got %h want %h", c, bus_addr, exp_addr);
        end
      end
    end
    m_req = 2'b00;
    tick();
  endtask

  task automatic test_reset_midop;
    set_m(0, 1'b0, 3'd0, 32'd0);
    m_req = 2'b01;
    tick(); tick();
    n_checks++; if (m_rdata !== 32'h1) begin n_fail++; $display("FAIL mid_pre: got %h want 1", m_rdata); end
    m_req = 2'b00;
    tick();
    set_m(1, 1'b0, 3'd5, 32'd0);
    m_req = 2'b01;
    tick();
    n_checks++; if (bus_ce !== 1'b1) begin n_fail++; $display("FAIL mid_access: got %b want 1", bus_ce); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus_ce !== 1'b0) begin n_fail++; $display("FAIL mid_ce: got %b want 0", bus_ce); end
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL mid_ack: got %b want 00", m_ack); end
    n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rdata: got %h want 0", m_rdata); end
    rst = 1'b0;
    m_req = 2'b11;
    tick();
    n_checks++; if (bus_ce !== 1'b1 || bus_addr !== 3'd0) begin
      n_fail++; $display("FAIL mid_regrant: got ce=%b addr=%h want ce=1 addr=0", bus_ce, bus_addr);
    end
    tick();
    n_checks++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL mid_ack2: got %b want 01", m_ack); end
    m_req = 2'b00;
    tick();
  endtask

  task automatic test_stale_req;
    set_m(1, 1'b1, 3'd4, 32'd7);
    m_req = 2'b10;
    tick(); tick();
    n_checks++; if (m_ack !== 2'b10) begin n_fail++; $display("FAIL st_ack1: got %b want 10", m_ack); end
    tick();
    n_checks++; if (bus_ce !== 1'b0) begin n_fail++; $display("FAIL st_idle: got %b want 0", bus_ce); end
    tick();
    n_checks++; if (bus_ce !== 1'b1) begin n_fail++; $display("FAIL st_second: got %b want 1", bus_ce); end
    tick();
    n_checks++; if (m_ack !== 2'b10) begin n_fail++; $display("FAIL st_ack2: got %b want 10", m_ack); end
    tick();
    m_req = 2'b00;
    tick();
    n_checks++; if (bus_ce !== 1'b0) begin n_fail++; $display("FAIL st_drop_ce: got %b want 0", bus_ce); end
    tick();
    n_checks++; if (m_ack !== 2'b00 || bus_ce !== 1'b0) begin
      n_fail++; $display("FAIL st_drop_ack: got ack=%b ce=%b want 00/0", m_ack, bus_ce);
    end
  endtask

  task automatic test_lock;
    logic [1:0] exp_ack;
    int         k;
    rst = 1'b1;
    m_req = 2'b00;
    m_lock = 2'b00;
    tick();
    rst = 1'b0;
    set_m(0, 1'b0, 3'd2, 32'd0);
    set_m(1, 1'b0, 3'd3, 32'd0);
    m_lock = 2'b01;
    m_req = 2'b11;
    for (int c = 1; c <= 17; c++) begin
      tick();
      k = c / 3;
      exp_ack = 2'b00;
      if (c % 3 == 2) begin
`ifdef ARB_LOCK_EN
        exp_ack = (k == 4) ? 2'b10 : 2'b01;
`else
        exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      end
      n_checks++; if (m_ack !== exp_ack) begin
        n_fail++; $display("FAIL lock_ack c=%0d: got %b want %b", c, m_ack, exp_ack);
      end
      if (c == 9) m_lock = 2'b00;
    end
    m_req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_preserves_rdata();
    test_contention();
    test_reset_midop();
    test_stale_req();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
